booth_multiplier: RTL and testbench



---
 rtl/booth_pkg.sv | 13 +
 rtl/booth_step.sv | 31 +++
 rtl/booth_multiplier.sv | 115 +++++++++++
 tb/tb_booth_multiplier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding
// and the default operand width.
package booth_pkg;

  localparam int WIDTH_DEFAULT = 8;

  // LOAD samples the operands, ITER retires one Booth step per clock
  typedef enum logic {
    LOAD = 1'b0,
    ITER = 1'b1
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand into the accumulator, then an arithmetic right shift of the
// combined {acc, q, q_1} register.
module booth_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  // Select add/sub/none from the Booth pair, then shift right replicating the guard MSB
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    q_next   = {sum[0], q[WIDTH-1:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Free-running sequential radix-2 Booth multiplier. Samples A/B in LOAD,
// runs WIDTH Booth steps in ITER, registers the signed product on Output and
// pulses done for one cycle, then immediately restarts on the current operands.
// The accumulator and multiplicand carry one guard bit so that the
// most-negative by most-negative product is exact.
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   Output,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state_reg;
  state_t             state_next;
  logic [CW-1:0]      count_reg;
  logic [WIDTH:0]     m_reg;
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_1_reg;
  logic [2*WIDTH-1:0] output_reg;
  logic               done_reg;

  logic               load_en;
  logic               step_en;
  logic               last_step;

  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               q_1_next;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .acc_next (acc_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: one LOAD cycle, then ITER until the final Booth step retires
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    state_next = ITER;
      ITER:    state_next = last_step ? LOAD : ITER;
      default: state_next = LOAD;
    endcase
  end

  // FSM outputs: datapath enables and the final-step marker
  always_comb begin
    load_en   = (state_reg == LOAD);
    step_en   = (state_reg == ITER);
    last_step = step_en && (count_reg == CW'(WIDTH - 1));
  end

  // Operand, accumulator and step-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg     <= '0;
      acc_reg   <= '0;
      q_reg     <= '0;
      q_1_reg   <= 1'b0;
      count_reg <= '0;
    end else if (load_en) begin
      m_reg     <= {A[WIDTH-1], A};
      acc_reg   <= '0;
      q_reg     <= B;
      q_1_reg   <= 1'b0;
      count_reg <= '0;
    end else if (step_en) begin
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      q_1_reg   <= q_1_next;
      count_reg <= count_reg + 1'b1;
    end
  end

  // Product register and done pulse, updated on the edge that completes the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      output_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= last_step;
      if (last_step) begin
        output_reg <= {acc_next[WIDTH-1:0], q_next};
      end
    end
  end

  assign Output = output_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier (WIDTH=8). The stimulus process
// drives operands ahead of each LOAD edge and pushes the expected product;
// the monitor pops and compares on every done pulse, checks that Output
// holds between pulses, and checks the reset values.
module tb_booth_multiplier;

  localparam int W = 8;

  typedef struct {
    logic signed [W-1:0]   a;
    logic signed [W-1:0]   b;
    logic signed [2*W-1:0] p;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic [2*W-1:0]        product;
  logic                  done;

  exp_t                  sb_q[$];
  logic                  rst_q;
  logic                  stim_done;
  int                    tests;
  int                    fails;

  booth_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (a),
    .B      (b),
    .Output (product),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Remember whether the most recent rising edge was a reset edge
  always @(posedge clk) rst_q <= rst;

  // Drive one operand pair into the LOAD edge, then scramble the inputs during
  // ITER; returns just after the edge that produces this pair's result.
  task automatic run_vec(input logic signed [W-1:0] va, input logic signed [W-1:0] vb,
                         input logic signed [2*W-1:0] vexp,
                         input logic signed [W-1:0] ja, input logic signed [W-1:0] jb);
    exp_t e;
    a = va;
    b = vb;
    e.a = va;
    e.b = vb;
    e.p = vexp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    a = ja;
    b = jb;
    repeat (W) @(posedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    logic signed [W-1:0]   ra;
    logic signed [W-1:0]   rb;
    logic signed [2*W-1:0] rp;
    logic signed [W-1:0]   tab_a [6];
    logic signed [W-1:0]   tab_b [6];
    logic signed [2*W-1:0] tab_p [6];

    tab_a = '{8'sd10,  -8'sd128, 8'sd127,  -8'sd5,  8'sd0,   -8'sd1};
    tab_b = '{8'sd14,  -8'sd128, -8'sd128, 8'sd3,   -8'sd77, -8'sd1};
    tab_p = '{16'sd140, 16'sd16384, -16'sd16256, -16'sd15, 16'sd0, 16'sd1};

    stim_done = 1'b0;
    rst = 1'b1;
    a = 8'sd10;
    b = 8'sd14;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Operands held from reset release: same product every period
    for (int i = 0; i < 3; i++) run_vec(8'sd10, 8'sd14, 16'sd140, 8'sd10, 8'sd14);

    // Operands change during ITER; the new pair is only seen at the next LOAD
    run_vec(8'sd10, 8'sd14, 16'sd140, 8'sd3, 8'sd3);
    run_vec(8'sd3, 8'sd3, 16'sd9, -8'sd99, 8'sd55);

    // Hand-computed vectors, including the guard-bit corner
    for (int i = 0; i < 6; i++) begin
      run_vec(tab_a[i], tab_b[i], tab_p[i], 8'($urandom), 8'($urandom));
    end

    // Reset asserted so that it lands on ITER step 4: the operation is aborted
    a = 8'sd7;
    b = 8'sd9;
    @(posedge clk);
    #1;
    a = 8'sd100;
    b = -8'sd100;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #7;
    rst = 1'b0;
    run_vec(-8'sd5, 8'sd3, -16'sd15, 8'sd1, 8'sd1);

    // Random signed pairs
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rp = ra * rb;
      run_vec(ra, rb, rp, 8'($urandom), 8'($urandom));
    end

    @(negedge clk);
    #1;
    stim_done = 1'b1;
  end

  // Monitor: all comparisons and the summary line live here
  initial begin
    exp_t                  e;
    logic [2*W-1:0]        hold_exp;
    hold_exp = '0;
    tests = 0;
    fails = 0;
    forever begin
      @(negedge clk);
      if (stim_done) begin
        tests++;
        if (sb_q.size() != 0) begin
          fails++;
          $display("[TB] FAIL pending_results: %0d results never arrived, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end else if (rst_q) begin
        tests++;
        if (product !== '0 || done !== 1'b0) begin
          fails++;
          $display("[TB] FAIL reset_state: Output=%h done=%b, required Output=0000 done=0", product, done);
        end
        hold_exp = '0;
      end else if (done === 1'b1) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_done: Output=%h with no result outstanding", product);
        end else begin
          e = sb_q.pop_front();
          hold_exp = e.p;
          if (product !== e.p) begin
            fails++;
            $display("[TB] FAIL product: A=%0d B=%0d Output=%0d (%h), required %0d (%h)",
                     e.a, e.b, $signed(product), product, e.p, e.p);
          end else begin
            $display("[TB] result A=%0d B=%0d Output=%0d ok", e.a, e.b, $signed(product));
          end
        end
      end else if (done !== 1'b0) begin
        tests++;
        fails++;
        $display("[TB] FAIL done_level: done=%b, required 0 or 1", done);
      end else begin
        tests++;
        if (product !== hold_exp) begin
          fails++;
          $display("[TB] FAIL output_hold: Output=%h between done pulses, required %h", product, hold_exp);
        end
      end
    end
  end

  // Bound on total run time
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete, required completion before 1000000");
    $fatal(1, "timeout");
  end

endmodule
